// File: rtl/floo_tgen_pkg.sv
// Shared definitions for the AXI traffic generator.
// Holds the FSM state type, the data pattern function, the watchdog limit and
// default AXI channel structs sized for the generator's default parameters
// (48-bit address, 512-bit data, 4-bit ID, 1-bit user).
package floo_tgen_pkg;

  typedef enum logic [2:0] {
    StIdle, StWrAw, StWrW, StWrB, StRdAr, StRdR, StDone
  } tgen_state_e;

  localparam int unsigned TgenWatchdogMax = 1023;

  localparam logic [1:0] AxiBurstIncr = 2'b01;
  localparam logic [1:0] AxiRespOkay  = 2'b00;

  localparam int unsigned TgenAddrWidth = 48;
  localparam int unsigned TgenDataWidth = 512;
  localparam int unsigned TgenIdWidth   = 4;
  localparam int unsigned TgenUserWidth = 1;

  // One 32-bit lane of the pattern for transaction t, beat b.
  function automatic logic [31:0] tgen_pattern(logic [31:0] seed, logic [15:0] t,
                                               logic [7:0] b, logic [31:0] lane);
    return seed ^ {t, b, 8'hA5} ^ lane;
  endfunction

  typedef struct packed {
    logic [TgenIdWidth-1:0]   id;
    logic [TgenAddrWidth-1:0] addr;
    logic [7:0]               len;
    logic [2:0]               size;
    logic [1:0]               burst;
    logic                     lock;
    logic [3:0]               cache;
    logic [2:0]               prot;
    logic [3:0]               qos;
    logic [3:0]               region;
    logic [5:0]               atop;
    logic [TgenUserWidth-1:0] user;
  } tgen_aw_chan_t;

  typedef struct packed {
    logic [TgenIdWidth-1:0]   id;
    logic [TgenAddrWidth-1:0] addr;
    logic [7:0]               len;
    logic [2:0]               size;
    logic [1:0]               burst;
    logic                     lock;
    logic [3:0]               cache;
    logic [2:0]               prot;
    logic [3:0]               qos;
    logic [3:0]               region;
    logic [TgenUserWidth-1:0] user;
  } tgen_ar_chan_t;

  typedef struct packed {
    logic [TgenDataWidth-1:0]   data;
    logic [TgenDataWidth/8-1:0] strb;
    logic                       last;
    logic [TgenUserWidth-1:0]   user;
  } tgen_w_chan_t;

  typedef struct packed {
    logic [TgenIdWidth-1:0]   id;
    logic [1:0]               resp;
    logic [TgenUserWidth-1:0] user;
  } tgen_b_chan_t;

  typedef struct packed {
    logic [TgenIdWidth-1:0]   id;
    logic [TgenDataWidth-1:0] data;
    logic [1:0]               resp;
    logic                     last;
    logic [TgenUserWidth-1:0] user;
  } tgen_r_chan_t;

  typedef struct packed {
    tgen_aw_chan_t aw;
    logic          aw_valid;
    tgen_w_chan_t  w;
    logic          w_valid;
    logic          b_ready;
    tgen_ar_chan_t ar;
    logic          ar_valid;
    logic          r_ready;
  } tgen_axi_req_t;

  typedef struct packed {
    logic         aw_ready;
    logic         ar_ready;
    logic         w_ready;
    logic         b_valid;
    tgen_b_chan_t b;
    logic         r_valid;
    tgen_r_chan_t r;
  } tgen_axi_rsp_t;

endpackage

// File: rtl/floo_tgen_pattern.sv
// Combinational DataWidth-wide pattern generator.
// Ports: txn (transaction index), beat (beat index), data (pattern word).
// Shared by the write data path and the read comparator.
module floo_tgen_pattern
  import floo_tgen_pkg::*;
#(
  parameter int unsigned DataWidth = 512,
  parameter logic [31:0] Seed      = 32'hC0FFEE
) (
  input  logic [15:0]          txn,
  input  logic [7:0]           beat,
  output logic [DataWidth-1:0] data
);

  for (genvar i = 0; i < DataWidth / 32; i++) begin : g_lane
    assign data[32*i +: 32] = tgen_pattern(Seed, txn, beat, 32'(i));
  end

endmodule

// File: rtl/floo_axi_traffic_gen.sv
// AXI4 manager traffic generator: writes NumTxns INCR bursts of a deterministic
// pattern, reads them back and compares beat by beat.
// Ports: clk_i, rst_ni (sync, active-low), start_i, axi_req_o, axi_rsp_i,
//        busy_o, done_o (sticky), err_cnt_o (saturating), txn_cnt_o.
// Optional: define FLOO_TGEN_WATCHDOG_EN to abort to DONE after 1023 stalled
// cycles on the active channel.
module floo_axi_traffic_gen
  import floo_tgen_pkg::*;
#(
  parameter int unsigned          AddrWidth = 48,
  parameter int unsigned          DataWidth = 512,
  parameter int unsigned          IdWidth   = 4,
  parameter int unsigned          UserWidth = 1,
  parameter logic [AddrWidth-1:0] BaseAddr  = '0,
  parameter logic [AddrWidth-1:0] TxnStride = 'h1000,
  parameter int unsigned          NumTxns   = 8,
  parameter int unsigned          BurstLen  = 4,
  parameter logic [31:0]          Seed      = 32'hC0FFEE,
  parameter type                  axi_req_t = tgen_axi_req_t,
  parameter type                  axi_rsp_t = tgen_axi_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  output axi_req_t    axi_req_o,
  input  axi_rsp_t    axi_rsp_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] err_cnt_o,
  output logic [16:0] txn_cnt_o
);

  localparam int unsigned    BurstBytes = BurstLen * DataWidth / 8;
  localparam logic [7:0]     LastBeat   = 8'(BurstLen - 1);
  localparam logic [15:0]    LastTxn    = 16'(NumTxns - 1);
  localparam logic [2:0]     AxSize     = 3'($clog2(DataWidth / 8));

  if (DataWidth < 32 || (DataWidth & (DataWidth - 1)) != 0) begin : g_bad_dw
    $error("DataWidth must be a power of two >= 32");
  end
  if (NumTxns < 1 || NumTxns > 65535 || BurstLen < 1 || BurstLen > 256) begin : g_bad_cnt
    $error("NumTxns or BurstLen out of range");
  end
  if (BurstBytes > 4096) begin : g_bad_burst
    $error("burst exceeds 4 KiB");
  end
  if (!((BaseAddr[11:0] == '0 && TxnStride[11:0] == '0) ||
        (4096 % BurstBytes == 0 && BaseAddr % BurstBytes == 0 &&
         TxnStride % BurstBytes == 0))) begin : g_bad_align
    $error("BaseAddr/TxnStride alignment lets a burst cross 4 KiB");
  end
  if ($bits(axi_req_o.aw.addr) != AddrWidth || $bits(axi_req_o.w.data) != DataWidth ||
      $bits(axi_req_o.aw.id) != IdWidth || $bits(axi_req_o.aw.user) != UserWidth ||
      $bits(axi_rsp_i.r.data) != DataWidth) begin : g_bad_types
    $error("axi_req_t/axi_rsp_t do not match the width parameters");
  end

  tgen_state_e          state_q, state_d;
  logic [15:0]          txn_q, txn_d;
  logic [7:0]           beat_q, beat_d;
  logic                 drain_q, drain_d;
  logic [15:0]          err_q, err_d;
  logic [16:0]          cnt_q, cnt_d;
  logic                 err_inc, burst_end, mismatch;
  logic [DataWidth-1:0] pat_data;
  logic [AddrWidth-1:0] txn_addr;

  assign txn_addr = BaseAddr + AddrWidth'(txn_q) * TxnStride;

  floo_tgen_pattern #(
    .DataWidth(DataWidth),
    .Seed     (Seed)
  ) u_pattern (
    .txn (txn_q),
    .beat(beat_q),
    .data(pat_data)
  );

`ifdef FLOO_TGEN_WATCHDOG_EN
  logic [9:0] wd_q, wd_d;
  logic       wd_hs, wd_busy;
`endif

  always_comb begin
    state_d   = state_q;
    txn_d     = txn_q;
    beat_d    = beat_q;
    drain_d   = drain_q;
    cnt_d     = cnt_q;
    err_inc   = 1'b0;
    burst_end = 1'b0;
    mismatch  = 1'b0;

    axi_req_o              = '0;
    axi_req_o.aw.addr      = txn_addr;
    axi_req_o.aw.len       = LastBeat;
    axi_req_o.aw.size      = AxSize;
    axi_req_o.aw.burst     = AxiBurstIncr;
    axi_req_o.ar.addr      = txn_addr;
    axi_req_o.ar.len       = LastBeat;
    axi_req_o.ar.size      = AxSize;
    axi_req_o.ar.burst     = AxiBurstIncr;
    axi_req_o.w.data       = pat_data;
    axi_req_o.w.strb       = '1;
    axi_req_o.w.last       = (beat_q == LastBeat);

    unique case (state_q)
      StIdle: if (start_i) state_d = StWrAw;
      StWrAw: begin
        axi_req_o.aw_valid = 1'b1;
        if (axi_rsp_i.aw_ready) state_d = StWrW;
      end
      StWrW: begin
        axi_req_o.w_valid = 1'b1;
        if (axi_rsp_i.w_ready) begin
          if (beat_q == LastBeat) begin
            beat_d  = '0;
            state_d = StWrB;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      StWrB: begin
        axi_req_o.b_ready = 1'b1;
        if (axi_rsp_i.b_valid) begin
          err_inc = (axi_rsp_i.b.resp != AxiRespOkay);
          cnt_d   = cnt_q + 17'd1;
          if (txn_q == LastTxn) begin
            txn_d   = '0;
            state_d = StRdAr;
          end else begin
            txn_d   = txn_q + 16'd1;
            state_d = StWrAw;
          end
        end
      end
      StRdAr: begin
        axi_req_o.ar_valid = 1'b1;
        if (axi_rsp_i.ar_ready) state_d = StRdR;
      end
      StRdR: begin
        axi_req_o.r_ready = 1'b1;
        if (axi_rsp_i.r_valid) begin
          if (drain_q) begin
            // Overlong burst already charged one error; discard until last.
            burst_end = axi_rsp_i.r.last;
          end else begin
            mismatch = (axi_rsp_i.r.data != pat_data) ||
                       (axi_rsp_i.r.resp != AxiRespOkay) ||
                       (axi_rsp_i.r.last != (beat_q == LastBeat));
            err_inc  = mismatch;
            if (axi_rsp_i.r.last) begin
              burst_end = 1'b1;
            end else if (beat_q == LastBeat) begin
              drain_d = 1'b1;
            end else begin
              beat_d = beat_q + 8'd1;
            end
          end
        end
        if (burst_end) begin
          beat_d  = '0;
          drain_d = 1'b0;
          cnt_d   = cnt_q + 17'd1;
          if (txn_q == LastTxn) begin
            state_d = StDone;
          end else begin
            txn_d   = txn_q + 16'd1;
            state_d = StRdAr;
          end
        end
      end
      StDone: ;
      default: state_d = StIdle;
    endcase

`ifdef FLOO_TGEN_WATCHDOG_EN
    wd_hs   = (axi_req_o.aw_valid & axi_rsp_i.aw_ready) | (axi_req_o.w_valid & axi_rsp_i.w_ready) |
              (axi_rsp_i.b_valid & axi_req_o.b_ready) | (axi_req_o.ar_valid & axi_rsp_i.ar_ready) |
              (axi_rsp_i.r_valid & axi_req_o.r_ready);
    wd_busy = state_q inside {StWrAw, StWrW, StWrB, StRdAr, StRdR};
    wd_d    = '0;
    if (wd_busy && !wd_hs && state_d == state_q) begin
      // wd_q counts completed stall cycles; this is the 1023rd.
      if (wd_q == 10'(TgenWatchdogMax - 1)) begin
        state_d = StDone;
        err_inc = 1'b1;
      end else begin
        wd_d = wd_q + 10'd1;
      end
    end
`endif

    err_d = (err_inc && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      txn_q   <= '0;
      beat_q  <= '0;
      drain_q <= 1'b0;
      err_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      txn_q   <= txn_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FLOO_TGEN_WATCHDOG_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) wd_q <= '0;
    else         wd_q <= wd_d;
  end
`endif

  assign busy_o    = !(state_q inside {StIdle, StDone});
  assign done_o    = (state_q == StDone);
  assign err_cnt_o = err_q;
  assign txn_cnt_o = cnt_q;

  logic unused_rsp;
  assign unused_rsp = ^{axi_rsp_i.b.id, axi_rsp_i.b.user, axi_rsp_i.r.id, axi_rsp_i.r.user};

endmodule

// File: tb/tb_floo_axi_traffic_gen.sv
// Self-checking bench for floo_axi_traffic_gen with a small in-bench AXI
// responder, expectation queues and a handshake monitor.
module tb_floo_axi_traffic_gen;
  import floo_tgen_pkg::*;

  localparam logic [47:0] Base   = 48'h8000_0000;
  localparam logic [47:0] Stride = 48'h1000;
  localparam int          NTx    = 8;
  localparam int          BL     = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  tgen_axi_req_t req;
  tgen_axi_rsp_t rsp;
  logic          busy, done;
  logic [15:0]   err_cnt;
  logic [16:0]   txn_cnt;

  always #5 clk = ~clk;

  floo_axi_traffic_gen #(
    .BaseAddr (Base),
    .TxnStride(Stride),
    .NumTxns  (NTx),
    .BurstLen (BL)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .axi_req_o(req),
    .axi_rsp_i(rsp),
    .busy_o   (busy),
    .done_o   (done),
    .err_cnt_o(err_cnt),
    .txn_cnt_o(txn_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Responder fault knobs (-1 = none).
  int bp_en = 0;
  int slverr_txn = -1, flip_txn = -1, early_txn = -1, nolast_txn = -1;

  logic [47:0]  exp_aw_q[$];
  logic [47:0]  exp_ar_q[$];
  logic [511:0] exp_w_q[$];
  int           w_beats = 0;
  logic [511:0] w_hist[8];

  task automatic check(string name, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_extra(string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected handshake expected none", name);
  endtask

  function automatic logic [511:0] model_pat(int t, int b);
    logic [511:0] r;
    logic [15:0]  tt;
    logic [7:0]   bb;
    tt = t[15:0];
    bb = b[7:0];
    for (int i = 0; i < 16; i++) r[32*i +: 32] = 32'h00C0FFEE ^ {tt, bb, 8'hA5} ^ 32'(i);
    return r;
  endfunction

  function automatic int txn_of(logic [47:0] a);
    return int'((a - Base) >> 12);
  endfunction

  // Responder: samples handshakes at negedge, updates outputs #1 after posedge.
  initial begin : responder
    logic [511:0] mem [logic [47:0]];
    logic         aw_hs, w_hs, b_hs, ar_hs, r_hs, in_rst, w_last_s;
    logic [47:0]  aw_a, ar_a, wr_addr, rd_addr;
    logic [511:0] w_d;
    int           wbeat, b_pend, rd_active, r_idx, r_total, rt;
    rsp = '0;
    wr_addr = '0; rd_addr = '0; wbeat = 0; b_pend = 0; rd_active = 0; r_idx = 0;
    r_total = 0; rt = 0;
    forever begin
      @(negedge clk);
      aw_hs    = req.aw_valid & rsp.aw_ready;
      w_hs     = req.w_valid & rsp.w_ready;
      b_hs     = rsp.b_valid & req.b_ready;
      ar_hs    = req.ar_valid & rsp.ar_ready;
      r_hs     = rsp.r_valid & req.r_ready;
      aw_a     = req.aw.addr;
      ar_a     = req.ar.addr;
      w_d      = req.w.data;
      w_last_s = req.w.last;
      in_rst   = !rst_n;
      @(posedge clk);
      #1;
      if (in_rst) begin
        rsp = '0;
        wbeat = 0; b_pend = 0; rd_active = 0; r_idx = 0;
      end else begin
        if (aw_hs) begin wr_addr = aw_a; wbeat = 0; end
        if (w_hs) begin
          mem[wr_addr + 48'(wbeat * 64)] = w_d;
          wbeat++;
          if (w_last_s) b_pend = 1;
        end
        if (b_hs) rsp.b_valid = 1'b0;
        if (b_pend != 0 && !rsp.b_valid && (bp_en == 0 || $urandom_range(0, 1) == 1)) begin
          rsp.b_valid = 1'b1;
          rsp.b.resp  = (txn_of(wr_addr) == slverr_txn) ? 2'b10 : 2'b00;
          b_pend = 0;
        end
        if (ar_hs) begin
          rd_addr = ar_a; r_idx = 0; rd_active = 1; rt = txn_of(ar_a);
          r_total = (rt == early_txn) ? 2 : (rt == nolast_txn) ? BL + 1 : BL;
        end
        if (r_hs) begin
          rsp.r_valid = 1'b0;
          r_idx++;
          if (r_idx == r_total) rd_active = 0;
        end
        if (rd_active != 0 && !rsp.r_valid && (bp_en == 0 || $urandom_range(0, 1) == 1)) begin
          rsp.r_valid = 1'b1;
          rsp.r.resp  = 2'b00;
          rsp.r.data  = mem.exists(rd_addr + 48'(r_idx * 64)) ? mem[rd_addr + 48'(r_idx * 64)] : '0;
          if (rt == flip_txn && r_idx == 2) rsp.r.data[17] = ~rsp.r.data[17];
          rsp.r.last  = (r_idx == r_total - 1);
        end
        rsp.aw_ready = (bp_en == 0) || ($urandom_range(0, 1) == 1);
        rsp.w_ready  = (bp_en == 0) || ($urandom_range(0, 1) == 1);
        rsp.ar_ready = (bp_en == 0) || ($urandom_range(0, 1) == 1);
      end
    end
  end

  // Monitor: pops expectations on every handshake and checks AXI stability.
  initial begin : monitor
    logic         aw_st, w_st, ar_st;
    logic [47:0]  aw_a, ar_a;
    logic [511:0] w_d;
    int           wb;
    aw_st = 0; w_st = 0; ar_st = 0; aw_a = '0; ar_a = '0; w_d = '0; wb = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_st = 0; w_st = 0; ar_st = 0; wb = 0;
      end else begin
        if (aw_st) check("aw_stable", {req.aw_valid, req.aw.addr}, {1'b1, aw_a});
        if (w_st)  check("w_stable", {req.w_valid, req.w.data}, {1'b1, w_d});
        if (ar_st) check("ar_stable", {req.ar_valid, req.ar.addr}, {1'b1, ar_a});
        if (req.aw_valid && rsp.aw_ready) begin
          if (exp_aw_q.size() == 0) fail_extra("aw_extra");
          else check("aw_addr", req.aw.addr, exp_aw_q.pop_front());
        end
        if (req.w_valid && rsp.w_ready) begin
          if (w_beats < 8) w_hist[w_beats] = req.w.data;
          check("w_last", req.w.last, wb == BL - 1);
          check("w_strb", req.w.strb, {64{1'b1}});
          if (exp_w_q.size() == 0) fail_extra("w_extra");
          else check("w_data", req.w.data, exp_w_q.pop_front());
          wb = (wb == BL - 1) ? 0 : wb + 1;
          w_beats++;
        end
        if (req.ar_valid && rsp.ar_ready) begin
          if (exp_ar_q.size() == 0) fail_extra("ar_extra");
          else check("ar_addr", req.ar.addr, exp_ar_q.pop_front());
        end
        aw_st = req.aw_valid && !rsp.aw_ready; aw_a = req.aw.addr;
        w_st  = req.w_valid && !rsp.w_ready;   w_d  = req.w.data;
        ar_st = req.ar_valid && !rsp.ar_ready; ar_a = req.ar.addr;
      end
    end
  end

  task automatic reset_dut();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_aw_q.delete(); exp_ar_q.delete(); exp_w_q.delete();
    w_beats = 0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push_expect();
    for (int t = 0; t < NTx; t++) begin
      exp_aw_q.push_back(Base + 48'(t) * Stride);
      exp_ar_q.push_back(Base + 48'(t) * Stride);
      for (int b = 0; b < BL; b++) exp_w_q.push_back(model_pat(t, b));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_and_check(string name, int exp_err);
    int n;
    push_expect();
    pulse_start();
    check({name, "_busy"}, busy, 1'b1);
    n = 0;
    while (!done && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_done"}, done, 1'b1);
    check({name, "_busy_end"}, busy, 1'b0);
    check({name, "_err"}, err_cnt, 16'(exp_err));
    check({name, "_txn"}, txn_cnt, 17'd16);
    check({name, "_aw_left"}, exp_aw_q.size(), 0);
    check({name, "_ar_left"}, exp_ar_q.size(), 0);
    check({name, "_w_left"}, exp_w_q.size(), 0);
  endtask

  initial begin : main
    int n;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valids", {req.aw_valid, req.w_valid, req.ar_valid, req.b_ready, req.r_ready}, 5'b0);
    check("rst_status", {busy, done, err_cnt, txn_cnt}, '0);
    reset_dut();

    // Nominal run, no backpressure.
    run_and_check("nominal", 0);
    check("w_t0b0_lane0", w_hist[0][31:0], 32'h00C0FF4B);
    check("w_t0b0_lane1", w_hist[0][63:32], 32'h00C0FF4A);
    check("w_t1b2_lane3", w_hist[6][127:96], 32'h00C1FD48);

    // Start in DONE must not restart.
    pulse_start();
    repeat (5) @(posedge clk);
    #1;
    check("restart_ignored", {done, busy, txn_cnt}, {1'b1, 1'b0, 17'd16});

    reset_dut();
    bp_en = 1;
    run_and_check("backpressure", 0);
    bp_en = 0;

    reset_dut();
    slverr_txn = 3;
    run_and_check("slverr", 1);
    slverr_txn = -1;

    reset_dut();
    flip_txn = 5; early_txn = 6;
    run_and_check("corrupt", 2);
    flip_txn = -1; early_txn = -1;

    reset_dut();
    nolast_txn = 2;
    run_and_check("nolast", 1);
    nolast_txn = -1;

    // Reset part-way through the write burst of txn 1.
    reset_dut();
    push_expect();
    pulse_start();
    n = 0;
    while (w_beats < BL + 2 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("midrst_reached", w_beats >= BL + 2, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_outputs", {req.aw_valid, req.w_valid, req.ar_valid, busy, done, err_cnt,
                             txn_cnt}, '0);
    reset_dut();
    run_and_check("after_rst", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
